// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared state encodings and width default for the
//               shared-counter controller.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

  localparam int C_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/cnt_core.sv
`default_nettype none
// ============================================================================
// Module      : cnt_core
// Description : Synchronous up-counter with clear (priority) and enable.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_core
  import counter_pkg::*;
#(
  parameter int WIDTH = C_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + C_ONE;
    end
  end

endmodule : cnt_core
`default_nettype wire

// File: rtl/counter_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : counter_share_ctrl
// Description : Round-robin arbiter granting one shared up-counter to two
//               requesters; counts to a latched target and pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_share_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH = C_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] tgt0,
  input  logic [WIDTH-1:0] tgt1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic [WIDTH-1:0] cnt
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_gnt;
  logic [1:0]       w_gnt_nxt;
  logic [1:0]       r_done;
  logic [1:0]       w_done_nxt;
  logic [WIDTH-1:0] r_tgt_q;
  logic [WIDTH-1:0] w_tgt_nxt;
  logic             r_prio;      // requester that wins the next tie
  logic             w_prio_nxt;
  logic             w_win;
  logic             w_owner;
  logic             w_owner_req;
  logic             w_at_tgt;
  logic             w_cnt_clr;
  logic             w_cnt_en;

  cnt_core #(
    .WIDTH (WIDTH)
  ) u_cnt_core (
    .clk (clk),
    .rst (rst),
    .clr (w_cnt_clr),
    .en  (w_cnt_en),
    .q   (cnt)
  );

  always_comb begin
    w_win = 1'b0;
    case (req)
      2'b01:   w_win = 1'b0;
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = r_prio;
      default: w_win = 1'b0;
    endcase
  end

  assign w_owner     = r_gnt[1];
  assign w_owner_req = req[w_owner];
  assign w_at_tgt    = (cnt == r_tgt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= 2'b00;
      r_done  <= 2'b00;
      r_tgt_q <= '0;
      r_prio  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_tgt_q <= w_tgt_nxt;
      r_prio  <= w_prio_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = 2'b00;
    w_tgt_nxt   = r_tgt_q;
    w_prio_nxt  = r_prio;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req != 2'b00) begin
          w_state_nxt = RUN;
          w_gnt_nxt   = w_win ? 2'b10 : 2'b01;
          w_tgt_nxt   = w_win ? tgt1 : tgt0;
          w_cnt_clr   = 1'b1;
        end
      end
      RUN: begin
        // An abandoned request wins over reaching the target: no done pulse.
        if (!w_owner_req) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = 2'b00;
          w_prio_nxt  = ~w_owner;
        end else if (w_at_tgt) begin
          w_state_nxt = DONE;
          w_done_nxt  = r_gnt;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = 2'b00;
        w_prio_nxt  = ~w_owner;
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = 2'b00;
      end
    endcase
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign busy = (r_state != IDLE);

endmodule : counter_share_ctrl
`default_nettype wire

// File: doc/counter_share_ctrl.md
COUNTER_SHARE_CTRL -- requirements
Module: counter_share_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, sets the counter and target width in bits.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  2  per-requester request; bit i is requester i; held high until done[i] or abandoned.
REQ-005 tgt0  input  WIDTH  requester 0 terminal count, sampled at grant.
REQ-006 tgt1  input  WIDTH  requester 1 terminal count, sampled at grant.
REQ-007 gnt  output  2  one-hot grant of the shared counter; all-zero when idle.
REQ-008 done  output  2  one-cycle completion pulse to the granted requester.
REQ-009 busy  output  1  high while the counter is owned (RUN or DONE).
REQ-010 cnt  output  WIDTH  current shared-counter value.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 In IDLE with req nonzero, the block SHALL, on the next edge, enter RUN, set gnt one-hot to the winner, latch the winner's target into tgt_q and clear cnt to 0.
REQ-013 Arbitration SHALL be round-robin: with both requests high, the requester not served last wins; after reset, requester 0 wins the first tie.
REQ-014 A single active request SHALL always win regardless of round-robin history.
REQ-015 In RUN, if cnt equals tgt_q the next edge SHALL enter DONE; otherwise cnt SHALL increment by 1.
REQ-016 Latency: a grant with target T SHALL give done high T+1 edges after the grant edge (T=0 gives done on the first edge after the grant).
REQ-017 cnt SHALL never wrap: it stops at tgt_q, so T = 2^WIDTH-1 counts fully without overflow.
REQ-018 In DONE, done[owner] SHALL be high for exactly one cycle, gnt SHALL remain asserted, and the next edge SHALL enter IDLE with gnt cleared and the last-served pointer set to the owner.
REQ-019 Changes to tgt0/tgt1 after the grant edge SHALL be ignored until the next grant.
REQ-020 If the owner drops req during RUN, the next edge SHALL abort to IDLE: gnt cleared, no done pulse, cnt held, and the pointer updated to the owner.
REQ-021 Requests arriving during RUN/DONE SHALL wait; no preemption.
REQ-022 A requester holding req through DONE SHALL re-arbitrate in IDLE on equal terms under REQ-013.
REQ-023 busy SHALL equal (state != IDLE).
REQ-024 done and gnt SHALL be registered outputs, free of combinational paths from req.

Reset
REQ-025 While rst is high on a clk edge: state = IDLE, gnt = 0, done = 0, cnt = 0, tgt_q = 0, and the pointer selects requester 0 for the next tie.
REQ-026 Reset asserted mid-RUN or mid-DONE SHALL take priority over all other transitions and suppress any pending done pulse.

Structure
REQ-027 A shared package counter_pkg SHALL hold the state encodings (IDLE=0, RUN=1, DONE=2) and the WIDTH default.
REQ-028 The counter SHALL be one sub-module, cnt_core (clk, rst, clr, en, q), a synchronous up-counter driven by the FSM.
REQ-029 Arbitration and FSM logic SHALL reside in counter_share_ctrl.

Verification
REQ-030 Reset then req=01, tgt0=3 -> gnt=01 after 1 edge; cnt 0,1,2,3; done=01 exactly on edge 4 after grant; gnt=00 on the following edge.
REQ-031 req=11 from reset, tgt0=2, tgt1=1, both held -> requester 0 served first, then requester 1, then requester 0 again (alternating grants).
REQ-032 req=10, tgt1=0 -> done=10 on the first edge after the grant; cnt stays 0.
REQ-033 req=01, tgt0=15 (WIDTH=4), tgt0 changed to 2 mid-run -> cnt reaches 15, never wraps; done after 16 edges.
REQ-034 req=01, tgt0=9, req dropped at cnt=4 -> IDLE next edge, no done pulse, gnt=00; a subsequent req=11 grants requester 1.
REQ-035 rst pulsed at cnt=5 of a run -> all outputs 0 after the reset edge; no done pulse emitted.
